// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU writeback/forwarding slice.
package spu_pkg;
    localparam int SPU_REG_W    = 7;
    localparam int SPU_QW       = 128;
    localparam int SPU_RD_PORTS = 6;

    typedef struct packed {
        logic                 valid;
        logic [SPU_REG_W-1:0] reg_addr;
        logic [SPU_QW-1:0]    data;
        logic [2:0]           lat;
    } wb_slot_t;

    // Latency codes below the fastest unit's latency are raised to it.
    function automatic logic [2:0] clamp_lat(input logic [2:0] lat, input int lat_min);
        return (lat < 3'(lat_min)) ? 3'(lat_min) : lat;
    endfunction
endpackage

// File: rtl/spu_fwd_match.sv
// One read port's search of the in-flight slots: youngest match wins.
// SPU_WB_FWD_EN selects full forwarding; without it any match is a stall.
module spu_fwd_match
    import spu_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  wb_slot_t [DEPTH-1:0][1:0] slots,
    input  logic [SPU_REG_W-1:0]      rd_reg,
    input  logic                      rd_used,
    output logic                      hit,
    output logic [SPU_QW-1:0]         data,
    output logic                      pending
);
    logic found;
`ifdef SPU_WB_FWD_EN
    logic              ready;
    logic [SPU_QW-1:0] sel_data;
`else
    logic              unused_fields;
`endif

    // Walk oldest to youngest, lane 0 before lane 1, so the last match is the winner.
    always_comb begin
        found = 1'b0;
`ifdef SPU_WB_FWD_EN
        ready    = 1'b0;
        sel_data = '0;
`endif
        for (int k = DEPTH - 1; k >= 0; k--) begin
            for (int l = 0; l < 2; l++) begin
                if (slots[k][l].valid && (slots[k][l].reg_addr == rd_reg)) begin
                    found = 1'b1;
`ifdef SPU_WB_FWD_EN
                    ready    = (k + 1) >= int'(slots[k][l].lat);
                    sel_data = slots[k][l].data;
`endif
                end
            end
        end
    end

`ifdef SPU_WB_FWD_EN
    assign hit     = rd_used & found & ready;
    assign data    = hit ? sel_data : '0;
    assign pending = rd_used & found & ~ready;
`else
    assign unused_fields = ^slots;
    assign hit           = 1'b0;
    assign data          = '0;
    assign pending       = rd_used & found;
`endif
endmodule

// File: rtl/spu_wb_forward.sv
// Dual-issue 7-stage retirement pipeline with RF writeback and operand forwarding.
// Define SPU_WB_FWD_EN for forwarding; otherwise reads interlock until RF write.
module spu_wb_forward
    import spu_pkg::*;
#(
    parameter int DEPTH   = 7,
    parameter int LAT_MIN = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [1:0]                              res_valid,
    input  logic [1:0][SPU_REG_W-1:0]               res_reg,
    input  logic [1:0][SPU_QW-1:0]                  res_data,
    input  logic [1:0][2:0]                         res_lat,
    input  logic [SPU_RD_PORTS-1:0][SPU_REG_W-1:0]  rd_reg,
    input  logic [SPU_RD_PORTS-1:0]                 rd_used,
    output logic [SPU_RD_PORTS-1:0]                 fwd_hit,
    output logic [SPU_RD_PORTS-1:0][SPU_QW-1:0]     fwd_data,
    output logic                                    stall,
    output logic [1:0]                              rf_we,
    output logic [1:0][SPU_REG_W-1:0]               rf_waddr,
    output logic [1:0][SPU_QW-1:0]                  rf_wdata
);
    wb_slot_t [DEPTH-1:0][1:0]    slots_q;
    wb_slot_t [DEPTH-1:0][1:0]    slots_d;
    logic [SPU_RD_PORTS-1:0]      pending;
    logic                         same_dst;

    always_comb begin
        slots_d = slots_q;
        for (int k = DEPTH - 1; k > 0; k--) begin
            slots_d[k] = slots_q[k-1];
        end
        for (int n = 0; n < 2; n++) begin
            slots_d[0][n].valid    = res_valid[n];
            slots_d[0][n].reg_addr = res_reg[n];
            slots_d[0][n].data     = res_data[n];
            slots_d[0][n].lat      = clamp_lat(res_lat[n], LAT_MIN);
        end
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                for (int n = 0; n < 2; n++) begin
                    slots_d[k][n].valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        slots_q <= slots_d;
    end

    for (genvar gi = 0; gi < SPU_RD_PORTS; gi++) begin : g_port
        spu_fwd_match #(.DEPTH(DEPTH)) u_match (
            .slots   (slots_q),
            .rd_reg  (rd_reg[gi]),
            .rd_used (rd_used[gi]),
            .hit     (fwd_hit[gi]),
            .data    (fwd_data[gi]),
            .pending (pending[gi])
        );
    end

    assign stall = |pending;

    // p1 is later in program order, so it owns the register on a same-stage collision.
    assign same_dst = slots_q[DEPTH-1][0].valid & slots_q[DEPTH-1][1].valid &
                      (slots_q[DEPTH-1][0].reg_addr == slots_q[DEPTH-1][1].reg_addr);

    always_comb begin
        rf_we[0] = slots_q[DEPTH-1][0].valid & ~same_dst;
        rf_we[1] = slots_q[DEPTH-1][1].valid;
        for (int n = 0; n < 2; n++) begin
            rf_waddr[n] = rf_we[n] ? slots_q[DEPTH-1][n].reg_addr : '0;
            rf_wdata[n] = rf_we[n] ? slots_q[DEPTH-1][n].data     : '0;
        end
    end
endmodule

// File: doc/spu_wb_forward.md
# spu_wb_forward

Dual-issue result writeback and forwarding pipeline for the SPU. It accepts up to two results per cycle from the execute stage, one from the even pipe (p0) and one from the odd pipe (p1). Each result is held for a fixed 7-stage retirement window and then written to the register file on two write ports. While a result is in flight, it is forwarded back to the six register-fetch read ports (RA/RB/RC for each pipe), and a stall is raised when a needed operand has not finished computing.

## Interface
Parameters:
- DEPTH, 7: retirement stages; an entry is written to the RF while it sits in stage DEPTH.
- LAT_MIN, 2: minimum unit latency; smaller latency codes are clamped up to this value.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- res_valid  in  [1:0]  result valid; index 0 = p0, index 1 = p1.
- res_reg  in  [1:0][6:0]  destination register.
- res_data  in  [1:0][127:0]  result quadword.
- res_lat  in  [1:0][2:0]  unit latency in cycles (2..7).
- rd_reg  in  [5:0][6:0]  read addresses; index 0..2 = RA/RB/RC of p0, index 3..5 = RA/RB/RC of p1.
- rd_used  in  [5:0]  read port carries a real operand this cycle.
- fwd_hit  out  [5:0]  forwarded value valid for that port.
- fwd_data  out  [5:0][127:0]  forwarded value.
- stall  out  1  an operand matches an in-flight result that is not yet ready.
- rf_we  out  [1:0]  RF write enable per port.
- rf_waddr  out  [1:0][6:0]  RF write address.
- rf_wdata  out  [1:0][127:0]  RF write data.

## Operation
- Storage is a shift pipeline of DEPTH stages × 2 lanes. Each slot holds valid, reg, data and lat; lat is clamped to at least LAT_MIN at capture.
- Each cycle:
  - stage k moves to stage k+1;
  - stage 1 captures the res_* inputs;
  - the entry leaving stage DEPTH is dropped.
- The pipeline never stalls itself. Upstream must gate res_valid while stall is high.
- An entry in stage k is "ready" when k ≥ lat.
- Forwarding, per read port i with rd_used[i]=1:
  - Search stages 1..DEPTH, both lanes, for valid entries with reg == rd_reg[i].
  - Priority: lowest stage number wins (youngest). Within the same stage, lane 1 wins over lane 0 (p1 is later in program order).
  - If the winning entry is ready: fwd_hit[i]=1 and fwd_data[i]=its data.
  - If the winning entry is not ready: fwd_hit[i]=0 and the port contributes to stall.
  - With no match, or with rd_used[i]=0: fwd_hit[i]=0 and fwd_data[i]=0.
- stall is the OR over all ports of "used, and youngest match not ready".
- RF write: rf_we[n] = valid of stage DEPTH lane n; address and data come from that slot.
  - If both lanes target the same register, rf_we[0] is forced to 0 (p1 result survives).
  - rf_waddr and rf_wdata are 0 whenever the corresponding rf_we is 0.
- Register 0 has no special meaning; it is forwarded and written like any other register.

## Timing
- Reset: all slot valid bits are cleared on the clock edge where reset=1. The outputs fwd_hit, fwd_data, stall, rf_we, rf_waddr and rf_wdata are all 0 during the cycle after that edge and remain 0 until new results arrive.
- Reset mid-operation: every in-flight result is discarded and no RF write occurs for it.
- A result presented in cycle t:
  - occupies stage 1 in cycle t+1;
  - becomes forwardable in cycle t+lat;
  - is driven on the RF write port in cycle t+DEPTH, for exactly one cycle.
- Forward and stall outputs are combinational from the slot state and rd_reg/rd_used. Writeback outputs depend only on registered state.
- A result is not forwardable in cycle t itself; the same-cycle EX bypass belongs to the EX stage.
- While an entry sits in stage DEPTH it is still forwarded, which covers the RF write-before-read window. Once it leaves, the RF holds the value.

## Configuration
- SPU_WB_FWD_EN defined: full forwarding as described above.
- SPU_WB_FWD_EN undefined:
  - fwd_hit and fwd_data are tied to 0;
  - stall is asserted for any used port matching any valid in-flight entry, regardless of readiness (full interlock until RF write);
  - writeback behaviour is unchanged.

## Structure
- spu_pkg holds:
  - typedef wb_slot_t (valid, reg[6:0], data[127:0], lat[2:0]);
  - constants SPU_REG_W=7, SPU_QW=128, SPU_RD_PORTS=6.
- Sub-module spu_fwd_match: one read port; scans the slot array and returns hit, data and pending. It is instantiated 6 times.

## Test plan
- Single result: p0 reg 5, data 0xA5…A5, lat 2 at cycle 0 → fwd_hit for reg 5 first seen in cycle 2 with stall=0; stall=1 in cycle 1; rf_we[0]=1, waddr=5 in cycle 7 only.
- Ordering: p0 reg 9 = 1 (lat 2) at cycle 0, p1 reg 9 = 2 (lat 2) at cycle 1 → read reg 9 at cycle 3 gives 2; in cycle 7 rf_we[0]=1 with data 1; in cycle 8 rf_we[1]=1 with data 2.
- Same-stage conflict: p0 and p1 both write reg 3 at cycle 0 (data 0x11 and 0x22, lat 4) → forwarded value 0x22 from cycle 4; in cycle 7 rf_we=2'b10, wdata[1]=0x22.
- Stall: p1 reg 20, lat 6 at cycle 0; RB of p0 reads 20 with rd_used=1 → stall=1 in cycles 1–5 and 0 in cycle 6; with rd_used=0, stall stays 0.
- Reset mid-flight: three results issued in cycles 0–2, reset=1 at cycle 3 → no rf_we asserted in cycles 4–10; all fwd_hit=0.
- Latency clamp: lat=0 at cycle 0 → behaves exactly as lat=2.
